// File: rtl/fifo_rd_checker.sv
// fifo_rd_checker: read-side FIFO drain that checks an incrementing sequence and reports the result
module fifo_rd_checker #(
  parameter int DATA_W    = 4,
  parameter int NUM_WORDS = 12,
  parameter int SEED      = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic              i_rclk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_empty,
  output logic              o_ren,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_timeout,
  output logic [7:0]        o_rd_cnt,
  output logic [7:0]        o_err_cnt,
  output logic [DATA_W-1:0] o_bad_got,
  output logic [DATA_W-1:0] o_bad_exp
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [7:0]        NW = 8'(NUM_WORDS);
  localparam logic [7:0]        TO = 8'(TIMEOUT);
  localparam logic [DATA_W-1:0] SD = DATA_W'(SEED);
  state_t            state_q, state_d;
  logic [7:0]        issued_q, issued_d, rd_cnt_q, rd_cnt_d, err_cnt_q, err_cnt_d, tmr_q, tmr_d;
  logic [DATA_W-1:0] exp_q, exp_d, bad_got_q, bad_got_d, bad_exp_q, bad_exp_d;
  logic              v_q, v_d, timeout_q, timeout_d;
  logic              start_ok, mis, first_mis, tmo_hit;
  assign start_ok  = i_start && (state_q == IDLE || state_q == DONE);
  assign mis       = v_q && (i_rdata != exp_q);
  assign first_mis = mis && (err_cnt_q == 8'd0);
  assign tmo_hit   = (state_q == RUN) && i_empty && (tmr_q + 8'd1 == TO);
  // state and datapath registers; reset clears everything asynchronously
  always_ff @(posedge i_rclk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      issued_q  <= '0;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
      tmr_q     <= '0;
      exp_q     <= '0;
      bad_got_q <= '0;
      bad_exp_q <= '0;
      v_q       <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
      tmr_q     <= tmr_d;
      exp_q     <= exp_d;
      bad_got_q <= bad_got_d;
      bad_exp_q <= bad_exp_d;
      v_q       <= v_d;
      timeout_q <= timeout_d;
    end
  end
  // next state: the last issue moves to DRAIN, the last compare or an empty timeout ends the run
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = i_start ? RUN : IDLE;
      RUN:     state_d = (o_ren && issued_q == NW - 8'd1) ? DRAIN : tmo_hit ? DONE : RUN;
      DRAIN:   state_d = v_q ? DONE : DRAIN;
      default: state_d = i_start ? RUN : DONE;
    endcase
  end
  // outputs: read enable is combinational, status is decoded from registered state
  always_comb begin
    o_ren     = (state_q == RUN) && !i_empty && (issued_q < NW);
    o_busy    = (state_q == RUN) || (state_q == DRAIN);
    o_done    = state_q == DONE;
    o_pass    = o_done && (err_cnt_q == 8'd0) && !timeout_q;
    o_timeout = timeout_q;
    o_rd_cnt  = rd_cnt_q;
    o_err_cnt = err_cnt_q;
    o_bad_got = bad_got_q;
    o_bad_exp = bad_exp_q;
  end
  // datapath: a start clears the run, otherwise compare the word read on the previous cycle
  always_comb begin
    v_d       = o_ren;
    issued_d  = start_ok ? 8'd0 : issued_q + {7'd0, o_ren};
    tmr_d     = (start_ok || o_ren) ? 8'd0 : (state_q == RUN && i_empty) ? tmr_q + 8'd1 : tmr_q;
    timeout_d = start_ok ? 1'b0 : timeout_q | tmo_hit;
    rd_cnt_d  = start_ok ? 8'd0 : rd_cnt_q + {7'd0, v_q};
    exp_d     = start_ok ? SD : v_q ? exp_q + 1'b1 : exp_q;
    err_cnt_d = start_ok ? 8'd0 : (mis && err_cnt_q != 8'hff) ? err_cnt_q + 8'd1 : err_cnt_q;
    bad_got_d = start_ok ? '0 : first_mis ? i_rdata : bad_got_q;
    bad_exp_d = start_ok ? '0 : first_mis ? exp_q : bad_exp_q;
  end
endmodule

// File: tb/tb_fifo_rd_checker.sv
// tb_fifo_rd_checker: FIFO model plus result scoreboard for two checker instances (12 and 20 words)
module tb_fifo_rd_checker;
  typedef struct {
    logic [7:0] rd;
    logic [7:0] err;
    logic       pass;
    logic       tmo;
    logic [3:0] bg;
    logic [3:0] be;
  } res_t;
  logic clk = 0, clk_en = 0, rst = 0, start_a = 0, start_b = 0, sel = 0, toggle_en = 0, phase = 0;
  logic [3:0] mem [0:63];
  logic [3:0] rdata = 0;
  logic empty, ren;
  int avail = 0, rp = 0, cyc = 0, last_ren = 0, checks = 0, failures = 0;
  res_t sb[$];
  logic ren_a, busy_a, done_a, pass_a, tmo_a, ren_b, busy_b, done_b, pass_b, tmo_b;
  logic [7:0] rd_a, err_a, rd_b, err_b;
  logic [3:0] bg_a, be_a, bg_b, be_b;

  fifo_rd_checker #(.DATA_W(4), .NUM_WORDS(12), .SEED(0), .TIMEOUT(16)) u_dut (
    .i_rclk(clk), .i_rst(rst), .i_start(start_a), .i_empty(empty), .o_ren(ren_a), .i_rdata(rdata),
    .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a), .o_timeout(tmo_a), .o_rd_cnt(rd_a),
    .o_err_cnt(err_a), .o_bad_got(bg_a), .o_bad_exp(be_a));

  fifo_rd_checker #(.DATA_W(4), .NUM_WORDS(20), .SEED(0), .TIMEOUT(16)) u_dut_w (
    .i_rclk(clk), .i_rst(rst), .i_start(start_b), .i_empty(empty), .o_ren(ren_b), .i_rdata(rdata),
    .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b), .o_timeout(tmo_b), .o_rd_cnt(rd_b),
    .o_err_cnt(err_b), .o_bad_got(bg_b), .o_bad_exp(be_b));

  assign ren   = ren_a | ren_b;
  assign empty = (rp >= avail) || (toggle_en && phase);

  always #5 if (clk_en) clk = ~clk;

  always @(posedge clk) begin
    if (ren) begin
      rdata <= mem[rp];
      rp    <= rp + 1;
    end
    phase <= ~phase;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (ren) begin
      last_ren = cyc;
      chk("ren_while_empty", empty, 0);
    end
  end

  task automatic append(input int n, input int ci, input logic [3:0] cv);
    for (int i = 0; i < n; i++) mem[avail + i] = (i == ci) ? cv : 4'(i);
    avail += n;
  endtask

  task automatic expect_push(input int base, input int cnt, input logic tmo);
    res_t r;
    r.rd = 8'(cnt); r.err = 0; r.bg = 0; r.be = 0; r.tmo = tmo;
    for (int i = 0; i < cnt; i++) begin
      logic [3:0] e;
      e = 4'(i);
      if (mem[base + i] != e) begin
        if (r.err == 0) begin
          r.bg = mem[base + i];
          r.be = e;
        end
        r.err++;
      end
    end
    r.pass = !tmo && r.err == 0;
    sb.push_back(r);
  endtask

  task automatic go();
    res_t r;
    logic seen;
    seen = 0;
    @(negedge clk);
    if (sel) start_b = 1; else start_a = 1;
    @(negedge clk);
    start_a = 0;
    start_b = 0;
    for (int k = 0; k < 600 && !seen; k++) begin
      #1;
      if (sel ? done_b : done_a) seen = 1;
      else @(negedge clk);
    end
    chk("done_wait", seen, 1);
    r = sb.pop_front();
    if (r.tmo) chk("tmo_latency", cyc - last_ren, 17);
    else chk("done_latency", cyc - last_ren, 2);
    chk("rd_cnt",  sel ? rd_b  : rd_a,  r.rd);
    chk("err_cnt", sel ? err_b : err_a, r.err);
    chk("pass",    sel ? pass_b : pass_a, r.pass);
    chk("timeout", sel ? tmo_b : tmo_a, r.tmo);
    chk("bad_got", sel ? bg_b : bg_a, r.bg);
    chk("bad_exp", sel ? be_b : be_a, r.be);
  endtask

  initial begin
    int base;
    #1 rst = 1;
    #20;
    chk("rst_noclk_a", {busy_a, done_a, pass_a, tmo_a, ren_a, rd_a, err_a, bg_a, be_a}, 0);
    chk("rst_noclk_b", {busy_b, done_b, pass_b, tmo_b, ren_b, rd_b, err_b, bg_b, be_b}, 0);
    clk_en = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    #1 chk("idle_after_rst", {busy_a, done_a, ren_a, busy_b, done_b, ren_b}, 0);
    // clean 12-word run
    base = avail; append(12, -1, 0); expect_push(base, 12, 0); go();
    // word 5 corrupted to A
    base = avail; append(12, 5, 4'hA); expect_push(base, 12, 0); go();
    // only three words, then empty until timeout
    base = avail; append(3, -1, 0); expect_push(base, 3, 1); go();
    // 20 words with wrap on the wide instance, empty toggling each cycle
    sel = 1; toggle_en = 1;
    base = avail; append(20, -1, 0); expect_push(base, 20, 0); go();
    sel = 0; toggle_en = 0;
    // reset in the middle of a run, then a clean rerun
    base = avail; append(4, -1, 0);
    @(negedge clk); start_a = 1; @(negedge clk); start_a = 0;
    for (int k = 0; k < 100 && rp < base + 4; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1 chk("pre_rst_rd_cnt", rd_a, 4);
    rst = 1;
    #1 chk("mid_rst_out", {rd_a, busy_a, ren_a, done_a}, 0);
    @(negedge clk); rst = 0;
    base = avail; append(12, -1, 0); expect_push(base, 12, 0); go();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
